// File: rtl/tdm_pkg.sv
// tdm_pkg: shared types and helpers for the TDM receive path.
// Holds the demux state enum, the default slot count and the
// even-parity helper used when TDM_PARITY_EN is defined.
package tdm_pkg;

  // Default number of data slots per frame (power of two, 2..16).
  localparam int DEFAULT_SLOTS = 16;

  // Frame-tracking states; PARITY is only entered with TDM_PARITY_EN.
  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    COLLECT = 2'd1,
    PARITY  = 2'd2
  } tdm_state_e;

  // Even parity over a frame: XOR of all data slots. Narrower frames are
  // zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic tdm_parity(input logic [DEFAULT_SLOTS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/tdm_demux_if.sv
// tdm_demux_if: serial slot input, frame handshake and status bundle.
// master = slot source / frame consumer side, slave = the demux itself.
interface tdm_demux_if
  import tdm_pkg::*;
#(
  parameter int SLOTS = DEFAULT_SLOTS
) ();

  localparam int SEL_W = $clog2(SLOTS);

  // serial side and consumer controls
  logic             en;
  logic             sync;
  logic             din;
  logic             frame_ready;
  logic             ovr_clr;

  // demux outputs
  logic [SEL_W-1:0] sel;
  logic             locked;
  logic [SLOTS-1:0] frame_data;
  logic             frame_valid;
  logic             parity_err;
  logic             sync_err;
  logic             overrun;

  modport master (
    output en, sync, din, frame_ready, ovr_clr,
    input  sel, locked, frame_data, frame_valid, parity_err, sync_err, overrun
  );

  modport slave (
    input  en, sync, din, frame_ready, ovr_clr,
    output sel, locked, frame_data, frame_valid, parity_err, sync_err, overrun
  );

endinterface

// File: rtl/tdm_slot_ctr.sv
// tdm_slot_ctr: slot index counter for the TDM demux.
// load forces the index to 1 (slot 0 is written by the sync strobe
// itself); inc advances it. Wraps naturally since SLOTS is a power of two.
module tdm_slot_ctr
  import tdm_pkg::*;
#(
  parameter int SLOTS = DEFAULT_SLOTS,
  parameter int SEL_W = $clog2(SLOTS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             inc,
  output logic [SEL_W-1:0] sel,
  output logic             last
);

  logic [SEL_W-1:0] sel_reg;

  // next-slot index: load on sync, advance on each collected slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_reg <= '0;
    end else if (load) begin
      sel_reg <= SEL_W'(1);
    end else if (inc) begin
      sel_reg <= sel_reg + SEL_W'(1);
    end
  end

  assign sel  = sel_reg;
  assign last = (sel_reg == SEL_W'(SLOTS - 1));

endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: time-division demultiplexer, receive end of a 16:1 mux stream.
// Strobed bits are gathered into a collection buffer, completed frames are
// handed off through a valid/ready register that is independent of the
// buffer, and resync / dropped-frame faults are flagged.
// Optional feature: define TDM_PARITY_EN to add a trailing even-parity slot
// and the PARITY state; otherwise parity_err is tied low.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int SLOTS = DEFAULT_SLOTS
) (
  input  logic        clk,
  input  logic        rst_n,
  tdm_demux_if.slave  bus
);

  localparam int SEL_W = $clog2(SLOTS);

  tdm_state_e       state_reg;
  logic             locked_reg;
  logic [SLOTS-1:0] buf_reg;
  logic [SLOTS-1:0] buf_next;
  logic [SLOTS-1:0] frame_data_reg;
  logic             frame_valid_reg;
  logic             parity_err_reg;
  logic             sync_err_reg;
  logic             overrun_reg;

  logic [SEL_W-1:0] sel;
  logic             last;
  logic             start;      // en with sync: slot 0 of a new frame
  logic             wr;         // data slot written into the buffer
  logic             take;       // consumer accepts the presented frame
  logic             complete;   // a whole frame is available this cycle
  logic [SLOTS-1:0] done_frame;
  logic             done_perr;

  assign start = bus.en && bus.sync;
  assign wr    = bus.en && !bus.sync && (state_reg == COLLECT);
  assign take  = frame_valid_reg && bus.frame_ready;

  tdm_slot_ctr #(
    .SLOTS (SLOTS),
    .SEL_W (SEL_W)
  ) u_slot_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (start),
    .inc   (wr),
    .sel   (sel),
    .last  (last)
  );

  // Per-slot buffer update: sync restarts the frame at slot 0 and clears the
  // stale partial bits, otherwise only the addressed slot takes din.
  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_slot
      assign buf_next[gi] = start ? ((gi == 0) ? bus.din : 1'b0)
                          : (wr && (sel == SEL_W'(gi))) ? bus.din
                          : buf_reg[gi];
    end
  endgenerate

  // collection buffer, separate from the presented frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_reg <= '0;
    end else begin
      buf_reg <= buf_next;
    end
  end

`ifdef TDM_PARITY_EN
  // Frame ends on the parity slot; the data bits are already in buf_reg.
  assign complete   = bus.en && !bus.sync && (state_reg == PARITY);
  assign done_frame = buf_reg;
  assign done_perr  = tdm_parity(DEFAULT_SLOTS'(buf_reg)) ^ bus.din;
`else
  // Frame ends on the last data slot; include the bit being written now.
  assign complete   = wr && last;
  assign done_frame = buf_next;
  assign done_perr  = 1'b0;
`endif

  // framing FSM plus the frame handshake and fault flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= HUNT;
      locked_reg      <= 1'b0;
      frame_data_reg  <= '0;
      frame_valid_reg <= 1'b0;
      parity_err_reg  <= 1'b0;
      sync_err_reg    <= 1'b0;
      overrun_reg     <= 1'b0;
    end else begin
      sync_err_reg <= 1'b0;

      case (state_reg)
        HUNT: begin
          if (start) begin
            state_reg  <= COLLECT;
            locked_reg <= 1'b1;
          end
        end
        COLLECT: begin
          if (start) begin
            // resync mid-frame: partial frame is dropped, restart at slot 1
            sync_err_reg <= 1'b1;
          end else if (wr && last) begin
`ifdef TDM_PARITY_EN
            state_reg  <= PARITY;
`else
            state_reg  <= HUNT;
            locked_reg <= 1'b0;
`endif
          end
        end
        PARITY: begin
          if (start) begin
            // a sync in place of the parity bit abandons the collected frame
            sync_err_reg <= 1'b1;
            state_reg    <= COLLECT;
          end else if (bus.en) begin
            state_reg  <= HUNT;
            locked_reg <= 1'b0;
          end
        end
        default: begin
          state_reg  <= HUNT;
          locked_reg <= 1'b0;
        end
      endcase

      // Present a finished frame if the output slot is free or being freed.
      if (complete && (!frame_valid_reg || take)) begin
        frame_data_reg  <= done_frame;
        parity_err_reg  <= done_perr;
        frame_valid_reg <= 1'b1;
      end else if (take) begin
        frame_valid_reg <= 1'b0;
      end

      // Dropped frame sets overrun; a set outranks a same-cycle clear.
      if (complete && frame_valid_reg && !take) begin
        overrun_reg <= 1'b1;
      end else if (bus.ovr_clr) begin
        overrun_reg <= 1'b0;
      end
    end
  end

  assign bus.sel         = sel;
  assign bus.locked      = locked_reg;
  assign bus.frame_data  = frame_data_reg;
  assign bus.frame_valid = frame_valid_reg;
  assign bus.parity_err  = parity_err_reg;
  assign bus.sync_err    = sync_err_reg;
  assign bus.overrun     = overrun_reg;

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed bench for tdm_demux (16 slots).
// Covers reset, plain and gapped frames, overrun and its clear, mid-frame
// resync, async reset mid-frame and, with TDM_PARITY_EN, the parity slot.
`timescale 1ns/1ps
module tb_tdm_demux;

  logic clk;
  logic rst_n;
  int   vec_cnt;
  int   err_cnt;
  int   serr_cnt;

  tdm_demux_if #(.SLOTS(16)) bus ();

  tdm_demux #(.SLOTS(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one line per compared value
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // one strobed slot; outputs sampled 1ns after the consuming edge
  task automatic send_slot(input logic s, input logic d);
    @(negedge clk);
    bus.en   = 1'b1;
    bus.sync = s;
    bus.din  = d;
    @(posedge clk);
    #1;
    bus.en   = 1'b0;
    bus.sync = 1'b0;
    if (bus.sync_err) serr_cnt++;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.en = 1'b0;
    @(posedge clk);
    #1;
    if (bus.sync_err) serr_cnt++;
  endtask

  // full frame, slot 0 carries sync, optional random gaps before each slot
  task automatic send_frame(input logic [15:0] w, input int maxgap, input logic pbit);
    int gap;
    for (int k = 0; k < 16; k++) begin
      gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      for (int g = 0; g < gap; g++) begin
        idle();
        if (k > 0) check("sel_hold", 32'(bus.sel), 32'(k));
      end
      send_slot(k == 0, w[k]);
    end
`ifdef TDM_PARITY_EN
    send_slot(1'b0, pbit);
`else
    if (pbit) idle();
`endif
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    serr_cnt = 0;
    rst_n = 1'b0;
    bus.en = 1'b0;
    bus.sync = 1'b0;
    bus.din = 1'b0;
    bus.frame_ready = 1'b1;
    bus.ovr_clr = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_sel", 32'(bus.sel), 32'd0);
    check("rst_locked", 32'(bus.locked), 32'd0);
    check("rst_data", 32'(bus.frame_data), 32'd0);
    check("rst_valid", 32'(bus.frame_valid), 32'd0);
    check("rst_perr", 32'(bus.parity_err), 32'd0);
    check("rst_serr", 32'(bus.sync_err), 32'd0);
    check("rst_ovr", 32'(bus.overrun), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // en without sync in HUNT is ignored
    send_slot(1'b0, 1'b1);
    check("hunt_ignore_sel", 32'(bus.sel), 32'd0);
    check("hunt_ignore_lock", 32'(bus.locked), 32'd0);

    // first slot locks and advances sel
    send_slot(1'b1, 1'b0);
    check("lock_sel", 32'(bus.sel), 32'd1);
    check("lock_locked", 32'(bus.locked), 32'd1);
    check("lock_valid", 32'(bus.frame_valid), 32'd0);

    // plain frame 3F0A, ready high (restart with sync; counts one resync)
    serr_cnt = 0;
    send_frame(16'h3F0A, 0, 1'b0);
    check("f1_valid", 32'(bus.frame_valid), 32'd1);
    check("f1_data", 32'(bus.frame_data), 32'h3F0A);
    check("f1_unlocked", 32'(bus.locked), 32'd0);
    check("f1_sel", 32'(bus.sel), 32'd0);
    check("f1_resync", 32'(serr_cnt), 32'd1);
    idle();
    check("f1_valid_1cyc", 32'(bus.frame_valid), 32'd0);

    // same frame with random gaps
    serr_cnt = 0;
    send_frame(16'h3F0A, 3, 1'b0);
    check("gap_valid", 32'(bus.frame_valid), 32'd1);
    check("gap_data", 32'(bus.frame_data), 32'h3F0A);
    check("gap_no_serr", 32'(serr_cnt), 32'd0);
    check("gap_no_ovr", 32'(bus.overrun), 32'd0);
    idle();

    // back-pressure: two frames with ready low
    bus.frame_ready = 1'b0;
    send_frame(16'h3F0A, 0, 1'b0);
    check("bp_valid1", 32'(bus.frame_valid), 32'd1);
    check("bp_ovr0", 32'(bus.overrun), 32'd0);
    send_frame(16'h00FF, 0, 1'b0);
    check("bp_valid2", 32'(bus.frame_valid), 32'd1);
    check("bp_ovr1", 32'(bus.overrun), 32'd1);
    check("bp_held", 32'(bus.frame_data), 32'h3F0A);
    @(negedge clk);
    bus.ovr_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.ovr_clr = 1'b0;
    check("clr_ovr", 32'(bus.overrun), 32'd0);
    check("clr_data", 32'(bus.frame_data), 32'h3F0A);
    @(negedge clk);
    bus.frame_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_taken", 32'(bus.frame_valid), 32'd0);

    // resync at slot 7 then full frame 00FF
    serr_cnt = 0;
    for (int k = 0; k < 7; k++) send_slot(k == 0, 1'b1);
    check("rs_sel7", 32'(bus.sel), 32'd7);
    send_frame(16'h00FF, 0, 1'b0);
    check("rs_serr_once", 32'(serr_cnt), 32'd1);
    check("rs_data", 32'(bus.frame_data), 32'h00FF);
    check("rs_valid", 32'(bus.frame_valid), 32'd1);
    idle();

`ifdef TDM_PARITY_EN
    // wrong parity bit then correct parity bit (XOR of 3F0A is 0)
    send_frame(16'h3F0A, 0, 1'b1);
    check("par_bad_valid", 32'(bus.frame_valid), 32'd1);
    check("par_bad_err", 32'(bus.parity_err), 32'd1);
    idle();
    send_frame(16'h3F0A, 0, 1'b0);
    check("par_ok_valid", 32'(bus.frame_valid), 32'd1);
    check("par_ok_err", 32'(bus.parity_err), 32'd0);
    idle();
`endif

    // async reset at slot 9 discards everything
    for (int k = 0; k < 9; k++) send_slot(k == 0, 1'b1);
    check("pre_rst_sel", 32'(bus.sel), 32'd9);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_sel", 32'(bus.sel), 32'd0);
    check("mid_rst_locked", 32'(bus.locked), 32'd0);
    check("mid_rst_data", 32'(bus.frame_data), 32'd0);
    check("mid_rst_valid", 32'(bus.frame_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    serr_cnt = 0;
    send_frame(16'hA5A5, 0, 1'b0);
    check("post_rst_valid", 32'(bus.frame_valid), 32'd1);
    check("post_rst_data", 32'(bus.frame_data), 32'hA5A5);
    check("post_rst_serr", 32'(serr_cnt), 32'd0);
    check("post_rst_perr", 32'(bus.parity_err), 32'd0);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
